// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte channel between NUM_REQ print engines.
// Optional grant revoke on idle timeout when ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int GUARD_CYC = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  input  logic [NUM_REQ-1:0]   req_tx_en,
  input  logic [8*NUM_REQ-1:0] req_tx_data,
  output logic [NUM_REQ-1:0]   req_tx_busy,
  input  logic                 uart_tx_busy,
  output logic                 uart_tx_en,
  output logic [7:0]           uart_tx_data,
  output logic                 timeout_evt
);

  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    DRAIN
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] next_ptr;
  logic [PW-1:0] pick;
  logic          pick_vld;
  logic [PW:0]   idx;
  logic [7:0]    hold;
  logic          hold_valid;
  logic [7:0]    guard;
  logic          busy_w;
  logic          accept;
  logic          send;

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_REQ))
        idx = idx - (PW+1)'(NUM_REQ);
      if (!pick_vld && req[idx[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[PW-1:0];
      end
    end
  end

  assign next_ptr = (owner == PW'(NUM_REQ-1)) ?
                    '0 : owner + 1'b1;
  assign busy_w   = hold_valid | (guard != 8'd0) | uart_tx_busy;
  assign accept   = (state == OWNED) && req_tx_en[owner] && !busy_w;
  assign send     = hold_valid && (guard == 8'd0) && !uart_tx_busy;

  always_comb begin
    req_tx_busy = '1;
    if (state == OWNED)
      req_tx_busy[owner] = busy_w;
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_quiet;
  logic        tmo_hit;

  assign tmo_quiet = (state == OWNED) && !accept &&
                     !hold_valid && (guard == 8'd0);
  assign tmo_hit   = tmo_quiet && (tmo_cnt == 16'(TIMEOUT-1));

  always_ff @(posedge clk) begin
    if (rst || !tmo_quiet || tmo_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 16'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= '0;
      rr_ptr       <= '0;
      owner        <= '0;
      hold         <= '0;
      hold_valid   <= 1'b0;
      guard        <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      timeout_evt  <= 1'b0;
    end else begin
      uart_tx_en  <= 1'b0;
      timeout_evt <= 1'b0;
      if (guard != 8'd0)
        guard <= guard - 8'd1;
      if (send) begin
        uart_tx_en   <= 1'b1;
        uart_tx_data <= hold;
        hold_valid   <= 1'b0;
        guard        <= 8'(GUARD_CYC);
      end
      if (accept) begin
        hold       <= req_tx_data[{owner, 3'b000} +: 8];
        hold_valid <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= NUM_REQ'(1) << pick;
            owner <= pick;
            state <= OWNED;
          end
        end
        OWNED: begin
          if (!req[owner])
            state <= DRAIN;
`ifdef ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            timeout_evt <= 1'b1;
            grant       <= '0;
            rr_ptr      <= next_ptr;
            state       <= IDLE;
          end
`endif
        end
        DRAIN: begin
          // release only once the last byte and its guard are gone
          if (!hold_valid && guard == 8'd0) begin
            grant  <= '0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple busy-for-10-cycles uart_tx model.
// Timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   req_tx_en = '0;
  logic [8*N-1:0] req_tx_data = '0;
  logic [N-1:0]   req_tx_busy;
  logic           uart_tx_busy;
  logic           uart_tx_en;
  logic [7:0]     uart_tx_data;
  logic           timeout_evt;

  logic           force_busy = 1'b0;
  int             bcnt;
  int             n_vec = 0;
  int             n_err = 0;
  int             n_sent = 0;
  logic [7:0]     sb[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .GUARD_CYC(2),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .grant(grant),
    .req_tx_en(req_tx_en),
    .req_tx_data(req_tx_data),
    .req_tx_busy(req_tx_busy),
    .uart_tx_busy(uart_tx_busy),
    .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data),
    .timeout_evt(timeout_evt)
  );

  always @(posedge clk) begin
    if (rst) bcnt <= 0;
    else if (uart_tx_en) bcnt <= 10;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign uart_tx_busy = force_busy | (bcnt != 0);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && uart_tx_en) begin
      n_sent++;
      chk("tx_while_busy", 32'(uart_tx_busy), 0);
      if (sb.size() == 0) chk("tx_unexpected", 1, 0);
      else chk("tx_data", 32'(uart_tx_data), 32'(sb.pop_front()));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_grant(input logic [N-1:0] exp, input string tag);
    int k = 0;
    while (grant == '0 && k < 50) begin
      tick();
      k++;
    end
    chk(tag, 32'(grant), 32'(exp));
  endtask

  task automatic wait_release(input string tag);
    int k = 0;
    while (grant != '0 && k < 200) begin
      tick();
      k++;
    end
    chk(tag, 32'(grant), 0);
  endtask

  task automatic send(input int i, input logic [7:0] b,
                      input bit expect_tx, input bit drop);
    int k = 0;
    while (req_tx_busy[i] && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) chk("busy_stuck", 32'(req_tx_busy[i]), 0);
    req_tx_en[i] = 1'b1;
    req_tx_data[8*i +: 8] = b;
    if (drop) req[i] = 1'b0;
    if (expect_tx) sb.push_back(b);
    tick();
    req_tx_en[i] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int k;
    logic [N-1:0] exp_g;
    int ord[2];

    // T1 reset and first grant latency
    tick(3);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(req_tx_busy), 32'hf);
    chk("rst_tx_en", 32'(uart_tx_en), 0);
    chk("rst_tx_data", 32'(uart_tx_data), 0);
    chk("rst_tmo", 32'(timeout_evt), 0);
    rst = 1'b0;
    req = 4'b0010;
    chk("t1_grant_pre", 32'(grant), 0);
    tick();
    chk("t1_grant", 32'(grant), 32'h2);

    // T2 three paced bytes
    send(1, 8'h41, 1, 0);
    send(1, 8'h42, 1, 0);
    send(1, 8'h43, 1, 0);
    req[1] = 1'b0;
    wait_release("t2_release");
    tick(15);
    chk("t2_sent", n_sent, 3);

    // T3 round-robin order
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    req = 4'hf;
    for (int i = 0; i < N; i++) begin
      exp_g = N'(1) << i;
      wait_grant(exp_g, "t3_grant");
      send(i, 8'h60 + 8'(i), 1, 0);
      req[i] = 1'b0;
      wait_release("t3_release");
    end
    req[0] = 1'b1;
    req[3] = 1'b1;
    ord[0] = 0;
    ord[1] = 3;
    for (int j = 0; j < 2; j++) begin
      exp_g = N'(1) << ord[j];
      wait_grant(exp_g, "t3_regrant");
      send(ord[j], 8'h70 + 8'(j), 1, 0);
      req[ord[j]] = 1'b0;
      wait_release("t3_rerelease");
    end

    // T4 byte strobed with req drop, stray strobe from req 0
    req[2] = 1'b1;
    wait_grant(4'b0100, "t4_grant");
    s0 = n_sent;
    send(2, 8'h55, 1, 1);
    chk("t4_hold_grant", 32'(grant), 32'h4);
    k = 0;
    while (grant != '0 && k < 100) begin
      if (k == 1) begin
        req_tx_en[0] = 1'b1;
        req_tx_data[7:0] = 8'haa;
      end
      tick();
      req_tx_en[0] = 1'b0;
      k++;
    end
    chk("t4_sent_first", n_sent - s0, 1);
    chk("t4_release", 32'(grant), 0);
    tick(15);

    // T5 reset while a byte is held
    req[1] = 1'b1;
    wait_grant(4'b0010, "t5_grant");
    send(1, 8'h77, 0, 0);
    force_busy = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("t5_rst_grant", 32'(grant), 0);
    chk("t5_rst_busy", 32'(req_tx_busy), 32'hf);
    rst = 1'b0;
    force_busy = 1'b0;
    req = '0;
    tick(20);
    chk("t5_grant", 32'(grant), 0);
    chk("t5_busy", 32'(req_tx_busy), 32'hf);
    chk("t5_tx_en", 32'(uart_tx_en), 0);

`ifdef ARB_TIMEOUT_EN
    // T6 silent owner gets revoked
    req = 4'b1000;
    wait_grant(4'b1000, "t6_grant");
    req[0] = 1'b1;
    k = 0;
    while (!timeout_evt && k < 40) begin
      tick();
      k++;
    end
    chk("t6_cycles", k, 16);
    chk("t6_revoked", 32'(grant), 0);
    tick();
    chk("t6_pulse", 32'(timeout_evt), 0);
    chk("t6_next", 32'(grant), 32'h1);
    req = '0;
    wait_release("t6_release");
`endif

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
